// File: rtl/riscv_core_mul_pkg.sv
// Shared types for the multiplier front end: opcode encoding, request payload
// and the skid buffer occupancy states.
package riscv_core_mul_pkg;

  localparam int XLEN = 64;
  localparam int TAGW = 5;
  localparam int HALF = XLEN / 2;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [XLEN:0]   multiplicand;
    logic [XLEN:0]   multiplier;
    logic            hisel;
    logic            isword;
    logic            zero;
    logic [TAGW-1:0] tag;
  } mul_req_t;

  localparam int MUL_REQ_W = $bits(mul_req_t);

endpackage

// File: rtl/riscv_core_mul_in_stage_if.sv
// Request/response bundle between the core, the operand stage and the array.
// master = surrounding core and array, slave = the operand stage.
interface riscv_core_mul_in_stage_if
  import riscv_core_mul_pkg::*;
();

  logic            i_mul_in_flush;
  logic            i_mul_in_valid;
  logic            o_mul_in_ready;
  logic [XLEN-1:0] i_mul_in_srcA;
  logic [XLEN-1:0] i_mul_in_srcB;
  logic [1:0]      i_mul_in_control;
  logic            i_mul_in_isword;
  logic [TAGW-1:0] i_mul_in_tag;

  logic            o_mul_in_valid;
  logic            i_mul_in_ready;
  logic [XLEN:0]   o_mul_in_multiplicand;
  logic [XLEN:0]   o_mul_in_multiplier;
  logic            o_mul_in_hisel;
  logic            o_mul_in_isword;
  logic            o_mul_in_zero;
  logic [TAGW-1:0] o_mul_in_tag;

  modport master (
    output i_mul_in_flush, i_mul_in_valid, i_mul_in_srcA, i_mul_in_srcB,
           i_mul_in_control, i_mul_in_isword, i_mul_in_tag, i_mul_in_ready,
    input  o_mul_in_ready, o_mul_in_valid, o_mul_in_multiplicand,
           o_mul_in_multiplier, o_mul_in_hisel, o_mul_in_isword,
           o_mul_in_zero, o_mul_in_tag
  );

  modport slave (
    input  i_mul_in_flush, i_mul_in_valid, i_mul_in_srcA, i_mul_in_srcB,
           i_mul_in_control, i_mul_in_isword, i_mul_in_tag, i_mul_in_ready,
    output o_mul_in_ready, o_mul_in_valid, o_mul_in_multiplicand,
           o_mul_in_multiplier, o_mul_in_hisel, o_mul_in_isword,
           o_mul_in_zero, o_mul_in_tag
  );

endinterface

// File: rtl/riscv_core_mul_skid.sv
// Generic 2-entry skid buffer: registered ready and valid, strict FIFO order,
// synchronous flush. The main register always holds the presented entry.
module riscv_core_mul_skid
  import riscv_core_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_acc;
  logic         out_acc;

  assign in_acc   = in_valid & in_ready;
  assign out_acc  = out_valid & out_ready;
  assign out_data = main_q;

  // Ready and valid are registered alongside the state so neither output
  // depends combinationally on the opposite side's handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_acc) begin
            main_q    <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            main_q <= in_data;
          end else if (in_acc) begin
            skid_q   <= in_data;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (out_acc) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (out_acc) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/riscv_core_mul_in_stage.sv
// Operand preparation in front of the radix-16 Booth array: extends rs1/rs2
// to XLEN+1 bits per opcode and registers the request through a skid buffer.
module riscv_core_mul_in_stage
  import riscv_core_mul_pkg::*;
(
  input logic                    i_clk,
  input logic                    i_rst_n,
  riscv_core_mul_in_stage_if.slave mul_if
);

  mul_op_e              op;
  mul_req_t             req_in;
  mul_req_t             req_out;
  logic [MUL_REQ_W-1:0] req_out_bits;

  assign op = mul_op_e'(mul_if.i_mul_in_control);

  // Word ops always sign-extend the low half; the upper source bits are
  // irrelevant and any control value behaves as MULW.
  always_comb begin
    req_in = '0;
    if (mul_if.i_mul_in_isword) begin
      req_in.multiplicand = {{(HALF + 1){mul_if.i_mul_in_srcA[HALF-1]}},
                             mul_if.i_mul_in_srcA[HALF-1:0]};
      req_in.multiplier   = {{(HALF + 1){mul_if.i_mul_in_srcB[HALF-1]}},
                             mul_if.i_mul_in_srcB[HALF-1:0]};
    end else begin
      req_in.multiplicand = {(op != MULHU) & mul_if.i_mul_in_srcA[XLEN-1],
                             mul_if.i_mul_in_srcA};
      req_in.multiplier   = {((op == MUL) | (op == MULH)) & mul_if.i_mul_in_srcB[XLEN-1],
                             mul_if.i_mul_in_srcB};
    end
    req_in.hisel  = ~mul_if.i_mul_in_isword & (op != MUL);
    req_in.isword = mul_if.i_mul_in_isword;
    req_in.zero   = (req_in.multiplicand == '0) | (req_in.multiplier == '0);
    req_in.tag    = mul_if.i_mul_in_tag;
  end

  riscv_core_mul_skid #(
    .W(MUL_REQ_W)
  ) u_skid (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .flush    (mul_if.i_mul_in_flush),
    .in_valid (mul_if.i_mul_in_valid),
    .in_ready (mul_if.o_mul_in_ready),
    .in_data  (req_in),
    .out_valid(mul_if.o_mul_in_valid),
    .out_ready(mul_if.i_mul_in_ready),
    .out_data (req_out_bits)
  );

  assign req_out = mul_req_t'(req_out_bits);

  assign mul_if.o_mul_in_multiplicand = req_out.multiplicand;
  assign mul_if.o_mul_in_multiplier   = req_out.multiplier;
  assign mul_if.o_mul_in_hisel        = req_out.hisel;
  assign mul_if.o_mul_in_isword       = req_out.isword;
  assign mul_if.o_mul_in_zero         = req_out.zero;
  assign mul_if.o_mul_in_tag          = req_out.tag;

endmodule

// File: tb/tb_riscv_core_mul_in_stage.sv
// Randomised bench for the multiplier operand stage against a queue-based
// model, plus directed literal cases for formatting, back-pressure, flush and reset.
module tb_riscv_core_mul_in_stage;
  import riscv_core_mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   cycle = 0;

  mul_req_t exp_q[$];
  int       log_tag[$];
  int       log_cycle[$];

  riscv_core_mul_in_stage_if bus();

  riscv_core_mul_in_stage dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .mul_if (bus.slave)
  );

  always #5 clk = ~clk;

  // Formatting rules written from the opcode semantics: signedness of each
  // operand, then plain signed extension to 65 bits.
  function automatic mul_req_t fmt_model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] ctrl, input logic w,
                                         input logic [4:0] tag);
    mul_req_t r;
    logic signed [64:0] ea, eb;
    logic signed [31:0] lo_a, lo_b;
    logic a_signed, b_signed;
    if (w) begin
      lo_a = a[31:0];
      lo_b = b[31:0];
      ea = lo_a;
      eb = lo_b;
    end else begin
      a_signed = (ctrl != 2'b11);
      b_signed = (ctrl == 2'b00) || (ctrl == 2'b01);
      if (a_signed) ea = $signed(a); else ea = $signed({1'b0, a});
      if (b_signed) eb = $signed(b); else eb = $signed({1'b0, b});
    end
    r.multiplicand = ea;
    r.multiplier   = eb;
    r.hisel        = !w && (ctrl != 2'b00);
    r.isword       = w;
    r.zero         = (ea == 0) || (eb == 0);
    r.tag          = tag;
    return r;
  endfunction

  function automatic mul_req_t dut_payload();
    mul_req_t r;
    r.multiplicand = bus.o_mul_in_multiplicand;
    r.multiplier   = bus.o_mul_in_multiplier;
    r.hisel        = bus.o_mul_in_hisel;
    r.isword       = bus.o_mul_in_isword;
    r.zero         = bus.o_mul_in_zero;
    r.tag          = bus.o_mul_in_tag;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] actual,
                             input logic [159:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference occupancy: FIFO of formatted requests, cleared on flush/reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      cycle <= cycle + 1;
      if (bus.i_mul_in_flush) begin
        exp_q.delete();
      end else begin
        if (bus.o_mul_in_valid && bus.i_mul_in_ready && exp_q.size() > 0)
          void'(exp_q.pop_front());
        if (bus.i_mul_in_valid && bus.o_mul_in_ready)
          exp_q.push_back(fmt_model(bus.i_mul_in_srcA, bus.i_mul_in_srcB,
                                    bus.i_mul_in_control, bus.i_mul_in_isword,
                                    bus.i_mul_in_tag));
      end
      if (bus.o_mul_in_valid && bus.i_mul_in_ready) begin
        log_tag.push_back(int'(bus.o_mul_in_tag));
        log_cycle.push_back(cycle);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_valid", bus.o_mul_in_valid, exp_q.size() != 0);
      checkOutput("model_ready", bus.o_mul_in_ready, exp_q.size() < 2);
      if (exp_q.size() != 0 && bus.o_mul_in_valid)
        checkOutput("model_payload", dut_payload(), exp_q[0]);
    end
  end

  // Holds a request until accepted; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic [1:0] ctrl, input logic w,
                               input logic [4:0] tag);
    logic accepted = 1'b0;
    bus.i_mul_in_valid   = 1'b1;
    bus.i_mul_in_srcA    = a;
    bus.i_mul_in_srcB    = b;
    bus.i_mul_in_control = ctrl;
    bus.i_mul_in_isword  = w;
    bus.i_mul_in_tag     = tag;
    for (int i = 0; i < 50; i++) begin
      if (bus.o_mul_in_ready) begin
        accepted = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.i_mul_in_valid = 1'b0;
    checkOutput("accept_timeout", accepted, 1'b1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int leaked;
  logic [63:0] ra, rb;

  initial begin
    bus.i_mul_in_flush   = 1'b0;
    bus.i_mul_in_valid   = 1'b0;
    bus.i_mul_in_srcA    = '0;
    bus.i_mul_in_srcB    = '0;
    bus.i_mul_in_control = '0;
    bus.i_mul_in_isword  = 1'b0;
    bus.i_mul_in_tag     = '0;
    bus.i_mul_in_ready   = 1'b1;

    #12;
    checkOutput("rst_valid", bus.o_mul_in_valid, 1'b0);
    checkOutput("rst_ready", bus.o_mul_in_ready, 1'b1);
    checkOutput("rst_payload", dut_payload(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // MULHU on all ones: both operands zero-extended
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 5'd1);
    checkOutput("mulhu_valid", bus.o_mul_in_valid, 1'b1);
    checkOutput("mulhu_mcand", bus.o_mul_in_multiplicand, 65'h0_FFFF_FFFF_FFFF_FFFF);
    checkOutput("mulhu_mplier", bus.o_mul_in_multiplier, 65'h0_FFFF_FFFF_FFFF_FFFF);
    checkOutput("mulhu_hisel", bus.o_mul_in_hisel, 1'b1);
    checkOutput("mulhu_zero", bus.o_mul_in_zero, 1'b0);

    applyStimulus(64'h1234_5678_8000_0000, 64'h0000_0000_0000_0003, 2'b00, 1'b1, 5'd2);
    checkOutput("mulw_mcand", bus.o_mul_in_multiplicand, 65'h1_FFFF_FFFF_8000_0000);
    checkOutput("mulw_mplier", bus.o_mul_in_multiplier, 65'h0_0000_0000_0000_0003);
    checkOutput("mulw_isword", bus.o_mul_in_isword, 1'b1);
    checkOutput("mulw_hisel", bus.o_mul_in_hisel, 1'b0);

    applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 1'b0, 5'd3);
    checkOutput("mulhsu_ext_a", bus.o_mul_in_multiplicand[64], 1'b1);
    checkOutput("mulhsu_ext_b", bus.o_mul_in_multiplier[64], 1'b0);
    checkOutput("mulhsu_hisel", bus.o_mul_in_hisel, 1'b1);

    applyStimulus(64'h0000_0000_0000_1234, 64'h0, 2'b00, 1'b0, 5'd4);
    checkOutput("mul_zero", bus.o_mul_in_zero, 1'b1);
    step(2);

    // Back-pressure: tags 1,2 fill the buffer, 3 stalls until release
    bus.i_mul_in_ready = 1'b0;
    applyStimulus(64'd5, 64'd6, 2'b00, 1'b0, 5'd1);
    applyStimulus(64'd7, 64'd8, 2'b01, 1'b0, 5'd2);
    checkOutput("bp_ready_low", bus.o_mul_in_ready, 1'b0);
    log_tag.delete();
    log_cycle.delete();
    fork
      applyStimulus(64'd9, 64'd10, 2'b11, 1'b0, 5'd3);
      begin
        step(3);
        checkOutput("bp_stall_tag", bus.o_mul_in_tag, 5'd1);
        checkOutput("bp_stall_ready", bus.o_mul_in_ready, 1'b0);
        bus.i_mul_in_ready = 1'b1;
      end
    join
    step(4);
    checkOutput("bp_count", log_tag.size(), 3);
    if (log_tag.size() >= 3) begin
      checkOutput("bp_order0", log_tag[0], 1);
      checkOutput("bp_order1", log_tag[1], 2);
      checkOutput("bp_order2", log_tag[2], 3);
      checkOutput("bp_no_bubble", log_cycle[1] - log_cycle[0], 1);
    end

    // Flush while TWO with a request pending, then flush in ONE with an accept
    bus.i_mul_in_ready = 1'b0;
    log_tag.delete();
    log_cycle.delete();
    applyStimulus(64'd11, 64'd12, 2'b00, 1'b0, 5'd10);
    applyStimulus(64'd13, 64'd14, 2'b00, 1'b0, 5'd11);
    bus.i_mul_in_valid = 1'b1;
    bus.i_mul_in_tag   = 5'd12;
    bus.i_mul_in_flush = 1'b1;
    step(1);
    bus.i_mul_in_flush = 1'b0;
    bus.i_mul_in_valid = 1'b0;
    checkOutput("flush2_valid", bus.o_mul_in_valid, 1'b0);
    checkOutput("flush2_ready", bus.o_mul_in_ready, 1'b1);
    applyStimulus(64'd15, 64'd16, 2'b00, 1'b0, 5'd14);
    bus.i_mul_in_valid = 1'b1;
    bus.i_mul_in_tag   = 5'd15;
    bus.i_mul_in_flush = 1'b1;
    step(1);
    bus.i_mul_in_flush = 1'b0;
    bus.i_mul_in_valid = 1'b0;
    checkOutput("flush1_valid", bus.o_mul_in_valid, 1'b0);
    bus.i_mul_in_ready = 1'b1;
    step(5);
    leaked = 0;
    foreach (log_tag[i]) if (log_tag[i] >= 10 && log_tag[i] <= 15) leaked++;
    checkOutput("flush_leak", leaked, 0);

    // Asynchronous reset while holding one entry
    bus.i_mul_in_ready = 1'b0;
    applyStimulus(64'hDEAD_BEEF, 64'h1, 2'b01, 1'b0, 5'd20);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", bus.o_mul_in_valid, 1'b0);
    checkOutput("arst_ready", bus.o_mul_in_ready, 1'b1);
    checkOutput("arst_payload", dut_payload(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_mul_in_ready = 1'b1;
    step(1);
    applyStimulus(64'd100, 64'd200, 2'b00, 1'b0, 5'd21);
    checkOutput("arst_latency_valid", bus.o_mul_in_valid, 1'b1);
    checkOutput("arst_latency_tag", bus.o_mul_in_tag, 5'd21);

    // Random traffic with back-pressure and occasional flush
    for (int i = 0; i < 600; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: rb = '0;
        2: ra = {32'h0, $urandom()};
        default: ;
      endcase
      bus.i_mul_in_valid   = ($urandom_range(0, 3) != 0);
      bus.i_mul_in_ready   = ($urandom_range(0, 9) < 6);
      bus.i_mul_in_flush   = ($urandom_range(0, 19) == 0);
      bus.i_mul_in_srcA    = ra;
      bus.i_mul_in_srcB    = rb;
      bus.i_mul_in_control = 2'($urandom_range(0, 3));
      bus.i_mul_in_isword  = ($urandom_range(0, 2) == 0);
      bus.i_mul_in_tag     = 5'($urandom_range(0, 31));
      step(1);
    end
    bus.i_mul_in_valid = 1'b0;
    bus.i_mul_in_flush = 1'b0;
    bus.i_mul_in_ready = 1'b1;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/riscv_core_mul_in_stage.md
Name: riscv_core_mul_in_stage

Overview:
Registered operand-preparation stage at the front of the radix-16 Booth multiplier.
- Accepts RV64M/RV32M multiply requests over a valid/ready handshake.
- Formats both operands to XLEN+1 bits with the correct sign or zero extension per opcode.
- Carries result-select information and a tag to the array.
- A 2-entry skid buffer gives full throughput with a registered o_mul_in_ready and absorbs one cycle of downstream back-pressure.

Parameters:
- XLEN, 64, register width; must be even and ≥ 8.
- TAGW, 5, width of the opaque request tag (destination register index).

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mul_in_flush  in  1  synchronous pipeline flush
- i_mul_in_valid  in  1  request valid
- o_mul_in_ready  out  1  stage can accept a request
- i_mul_in_srcA  in  XLEN  rs1
- i_mul_in_srcB  in  XLEN  rs2
- i_mul_in_control  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- i_mul_in_isword  in  1  word variant (MULW)
- i_mul_in_tag  in  TAGW  request tag
- o_mul_in_valid  out  1  formatted operands valid
- i_mul_in_ready  in  1  multiplier array accepts
- o_mul_in_multiplicand  out  XLEN+1  formatted rs1
- o_mul_in_multiplier  out  XLEN+1  formatted rs2
- o_mul_in_hisel  out  1  select upper XLEN bits of the product
- o_mul_in_isword  out  1  sign-extend the low XLEN/2 bits of the result
- o_mul_in_zero  out  1  either formatted operand is zero (early-out hint)
- o_mul_in_tag  out  TAGW  tag of the presented request

Behaviour:
- Handshakes:
  - Input handshake: i_mul_in_valid & o_mul_in_ready.
  - Output handshake: o_mul_in_valid & i_mul_in_ready.
  - o_mul_in_valid must not depend combinationally on i_mul_in_ready.
  - Output payload is held stable while o_mul_in_valid=1 and i_mul_in_ready=0.
- Formatting (combinational, before the register). Extension bits are written ext(A) for rs1 and ext(B) for rs2.
  - isword=0:
    - ext(A) = 0 if control=MULHU, else srcA[XLEN-1].
    - ext(B) = 0 if control ∈ {MULHSU, MULHU}, else srcB[XLEN-1].
    - Operand = {ext, src}.
  - isword=1: both operands are sign-extended from bit XLEN/2-1 to XLEN+1 bits. Upper XLEN/2 source bits are ignored. Any control value is treated as MULW.
  - hisel = ~isword & (control≠00).
  - zero = (formatted multiplicand==0) | (formatted multiplier==0).
- Latency: 1 cycle from input handshake to o_mul_in_valid when the stage is empty.
- Storage FSM over main and skid registers:
  - EMPTY: no entry held. Input accept → ONE.
  - ONE:
    - Input accept with no output accept → TWO (skid captures).
    - Accept on both sides → ONE (main reloads).
    - Output accept only → EMPTY.
  - TWO:
    - o_mul_in_ready=0.
    - Output accept → ONE; skid moves to main in the same cycle.
- o_mul_in_ready = registered (state≠TWO).
- Ordering is strictly FIFO. The skid entry is never presented before the main entry.
- Flush:
  - Next state is EMPTY.
  - Any input accepted in the flush cycle is dropped.
  - o_mul_in_valid=0 the following cycle.
  - o_mul_in_ready=1 the following cycle.
- Reset (async assert, release synchronised by the top level):
  - State EMPTY.
  - o_mul_in_valid=0, o_mul_in_ready=1.
  - All payload outputs 0.
  - Reset mid-transaction discards held entries without any output handshake.
- Payload registers load only on accept. No other enable path.

Decomposition:
- Package riscv_core_mul_pkg:
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU).
  - Packed struct mul_req_t {multiplicand, multiplier, hisel, isword, zero, tag}, parametrised through package localparams XLEN/TAGW.
  - skid_state_e (EMPTY, ONE, TWO).
- Sub-module riscv_core_mul_skid: generic 2-entry skid buffer parametrised by payload width. Contains the FSM, flush and handshakes.
- Formatting logic stays in riscv_core_mul_in_stage.

Test Plan:
- MULHU, srcA=srcB=0xFFFF_FFFF_FFFF_FFFF, downstream ready:
  - Output one cycle later: multiplicand = multiplier = {1'b0, all ones}.
  - hisel=1, zero=0.
- MULW, srcA=0x1234_5678_8000_0000, srcB=0x0000_0000_0000_0003:
  - multiplicand = 65'h1_FFFF_FFFF_8000_0000.
  - multiplier = 65'h0_0000_0000_0000_0003.
  - isword=1, hisel=0.
- MULHSU, srcA=0x8000_0000_0000_0000, srcB=0x8000_0000_0000_0000:
  - multiplicand ext bit = 1, multiplier ext bit = 0, hisel=1.
- Back-pressure: hold i_mul_in_ready=0 and push tags 1, 2, 3.
  - Tags 1 and 2 are accepted; o_mul_in_ready drops after the second accept; tag 3 stalls.
  - Release ready: outputs appear in order 1, 2, 3, with no bubble between 1 and 2.
- Flush in TWO state with i_mul_in_valid=1:
  - Next cycle: o_mul_in_valid=0, o_mul_in_ready=1.
  - The flushed tags never appear on the output.
- Assert i_rst_n=0 asynchronously while in ONE:
  - o_mul_in_valid=0 immediately, all payload outputs 0.
  - After release, the first request emerges with 1-cycle latency.
